vx_lru_repl_ctrl: RTL and testbench

Per-set true-LRU replacement controller for the set-associative cache. It takes tag-lookup outcomes (hit touches, fill allocations, invalidations) through a valid/ready request channel. It keeps a recency ranking and a valid bit for every way of every set. It returns the chosen way through a single-entry registered response channel. It sits directly upstream of the LRU queue/fill path, supplying the victim way that the fill data is written into.

---
 rtl/vx_lru_repl_ctrl.sv | 114 +++++++++++
 tb/tb_vx_lru_repl_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_lru_repl_ctrl.sv
// Per-set true-LRU replacement controller: ranks and valid bits per way, victim
// selection for fills, and a single-entry registered response channel.
module vx_lru_repl_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4,
    parameter int SETW     = $clog2(NUM_SETS),
    parameter int WAYW     = $clog2(NUM_WAYS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [SETW-1:0] req_set,
    input  logic [WAYW-1:0] req_way,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [WAYW-1:0] rsp_way,
    output logic            rsp_evict,
    input  logic            rsp_ready
);

    localparam logic [1:0] OP_TOUCH = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_INVAL = 2'd2;
    localparam logic [WAYW-1:0] MRU = WAYW'(NUM_WAYS - 1);

    logic [WAYW-1:0]     rank_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] vld_q  [NUM_SETS];

    logic [WAYW-1:0]     cur_rank [NUM_WAYS];
    logic [WAYW-1:0]     nxt_rank [NUM_WAYS];
    logic [NUM_WAYS-1:0] cur_vld;
    logic [NUM_WAYS-1:0] nxt_vld;
    logic [WAYW-1:0]     victim;
    logic [WAYW-1:0]     tgt_way;
    logic [WAYW-1:0]     tgt_rank;
    logic                any_free;
    logic                do_promote;
    logic                do_demote;
    logic                accept;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            cur_rank[w] = rank_q[req_set][w];
        end
        cur_vld = vld_q[req_set];
    end

    // Victim: lowest-index invalid way, otherwise the rank-0 (LRU) way
    always_comb begin
        victim   = '0;
        any_free = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!cur_vld[w]) begin
                victim   = WAYW'(w);
                any_free = 1'b1;
            end
        end
        if (!any_free) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (cur_rank[w] == '0) victim = WAYW'(w);
            end
        end
    end

    always_comb begin
        tgt_way    = (req_op == OP_FILL) ? victim : req_way;
        tgt_rank   = cur_rank[tgt_way];
        do_promote = (req_op == OP_FILL) || ((req_op == OP_TOUCH) && cur_vld[req_way]);
        do_demote  = (req_op == OP_INVAL);
        nxt_vld    = cur_vld;
        if (req_op == OP_FILL)  nxt_vld[tgt_way] = 1'b1;
        if (req_op == OP_INVAL) nxt_vld[tgt_way] = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            nxt_rank[w] = cur_rank[w];
            if (do_promote) begin
                if (WAYW'(w) == tgt_way)         nxt_rank[w] = MRU;
                else if (cur_rank[w] > tgt_rank) nxt_rank[w] = cur_rank[w] - WAYW'(1);
            end else if (do_demote) begin
                if (WAYW'(w) == tgt_way)         nxt_rank[w] = '0;
                else if (cur_rank[w] < tgt_rank) nxt_rank[w] = cur_rank[w] + WAYW'(1);
            end
        end
    end

    // Acceptance edge: set state and response register load together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    rank_q[s][w] <= WAYW'(w);
                end
                vld_q[s] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
            rsp_evict <= 1'b0;
        end else if (accept) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                rank_q[req_set][w] <= nxt_rank[w];
            end
            vld_q[req_set] <= nxt_vld;
            rsp_valid      <= 1'b1;
            rsp_way        <= tgt_way;
            rsp_evict      <= (req_op == OP_FILL) && cur_vld[victim];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_lru_repl_ctrl.sv
// Directed bench for vx_lru_repl_ctrl: fill order, touch/inval recency effects,
// backpressure, set isolation and asynchronous reset.
module tb_vx_lru_repl_ctrl;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 4;
    localparam int SETW     = 2;
    localparam int WAYW     = 2;

    localparam logic [1:0] TOUCH = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] INVAL = 2'd2;
    localparam logic [1:0] NOP   = 2'd3;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [SETW-1:0] req_set;
    logic [WAYW-1:0] req_way;
    logic            req_ready;
    logic            rsp_valid;
    logic [WAYW-1:0] rsp_way;
    logic            rsp_evict;
    logic            rsp_ready;

    int tests = 0;
    int fails = 0;

    vx_lru_repl_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_set(req_set), .req_way(req_way),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_way(rsp_way), .rsp_evict(rsp_evict),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a posedge; returns 1 time unit after the next posedge.
    task automatic send(input logic [1:0] op, input logic [SETW-1:0] s, input logic [WAYW-1:0] w);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = s;
        req_way   = w;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = NOP;
        req_set   = '0;
        req_way   = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic fill_set(input logic [SETW-1:0] s);
        for (int i = 0; i < NUM_WAYS; i++) send(FILL, s, '0);
    endtask

    task automatic test_reset();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_way !== 2'd0 || rsp_evict !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid=%0b way=%0d evict=%0b ready=%0b, want 0/0/0/1",
                     rsp_valid, rsp_way, rsp_evict, req_ready);
        end
    endtask

    task automatic test_cold_fill();
        logic [WAYW-1:0] exp_way [5];
        logic            exp_ev  [5];
        exp_way = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_ev  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL cold_pre_valid: valid=%0b, want 0", rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            send(FILL, 2'd1, '0);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_way !== exp_way[i] || rsp_evict !== exp_ev[i]) begin
                fails++;
                $display("FAIL cold_fill%0d: valid=%0b way=%0d evict=%0b, want 1/%0d/%0b",
                         i, rsp_valid, rsp_way, rsp_evict, exp_way[i], exp_ev[i]);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL cold_drain: valid=%0b, want 0", rsp_valid);
        end
    endtask

    task automatic test_touch_protects();
        do_reset();
        fill_set(2'd0);
        send(TOUCH, 2'd0, 2'd0);
        tests++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL touch_rsp: way=%0d evict=%0b, want 0/0", rsp_way, rsp_evict);
        end
        send(FILL, 2'd0, '0);
        tests++;
        if (rsp_way !== 2'd1 || rsp_evict !== 1'b1) begin
            fails++;
            $display("FAIL touch_fill1: way=%0d evict=%0b, want 1/1", rsp_way, rsp_evict);
        end
        send(FILL, 2'd0, '0);
        tests++;
        if (rsp_way !== 2'd2 || rsp_evict !== 1'b1) begin
            fails++;
            $display("FAIL touch_fill2: way=%0d evict=%0b, want 2/1", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_inval_reuse();
        do_reset();
        fill_set(2'd2);
        send(INVAL, 2'd2, 2'd2);
        tests++;
        if (rsp_way !== 2'd2 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL inval_rsp: way=%0d evict=%0b, want 2/0", rsp_way, rsp_evict);
        end
        send(FILL, 2'd2, '0);
        tests++;
        if (rsp_way !== 2'd2 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL inval_refill: way=%0d evict=%0b, want 2/0", rsp_way, rsp_evict);
        end
        // ranks now w0..w3 = 0,1,3,2; invalidate w1 and w3
        send(INVAL, 2'd2, 2'd1);
        send(INVAL, 2'd2, 2'd3);
        send(TOUCH, 2'd2, 2'd3);
        tests++;
        if (rsp_way !== 2'd3 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL touch_invalid_rsp: way=%0d evict=%0b, want 3/0", rsp_way, rsp_evict);
        end
        send(NOP, 2'd2, 2'd2);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd2 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL nop_rsp: valid=%0b way=%0d evict=%0b, want 1/2/0", rsp_valid, rsp_way, rsp_evict);
        end
        send(FILL, 2'd2, '0);
        tests++;
        if (rsp_way !== 2'd1 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL inval_fill_w1: way=%0d evict=%0b, want 1/0", rsp_way, rsp_evict);
        end
        send(FILL, 2'd2, '0);
        tests++;
        if (rsp_way !== 2'd3 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL inval_fill_w3: way=%0d evict=%0b, want 3/0", rsp_way, rsp_evict);
        end
        // full set, ranks 0,2,1,3 -> victims w0 then w2
        send(FILL, 2'd2, '0);
        tests++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b1) begin
            fails++;
            $display("FAIL inval_full1: way=%0d evict=%0b, want 0/1", rsp_way, rsp_evict);
        end
        send(FILL, 2'd2, '0);
        tests++;
        if (rsp_way !== 2'd2 || rsp_evict !== 1'b1) begin
            fails++;
            $display("FAIL inval_full2: way=%0d evict=%0b, want 2/1", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        send(FILL, 2'd0, '0);
        req_valid = 1'b1;
        req_op    = FILL;
        req_set   = 2'd0;
        req_way   = 2'd3;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_way !== 2'd0 || rsp_evict !== 1'b0 || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_c%0d: valid=%0b way=%0d evict=%0b ready=%0b, want 1/0/0/0",
                         c, rsp_valid, rsp_way, rsp_evict, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: ready=%0b, want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd1 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL stall_second: valid=%0b way=%0d evict=%0b, want 1/1/0", rsp_valid, rsp_way, rsp_evict);
        end
        send(FILL, 2'd0, '0);
        send(FILL, 2'd0, '0);
        tests++;
        if (rsp_way !== 2'd3 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL stall_fill4: way=%0d evict=%0b, want 3/0", rsp_way, rsp_evict);
        end
        send(FILL, 2'd0, '0);
        tests++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b1) begin
            fails++;
            $display("FAIL stall_ranks: way=%0d evict=%0b, want 0/1", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_set_isolation();
        do_reset();
        for (int i = 0; i < NUM_WAYS; i++) begin
            send(FILL, 2'd0, '0);
            tests++;
            if (rsp_way !== WAYW'(i) || rsp_evict !== 1'b0) begin
                fails++;
                $display("FAIL iso_s0_%0d: way=%0d evict=%0b, want %0d/0", i, rsp_way, rsp_evict, i);
            end
            send(FILL, 2'd3, '0);
            tests++;
            if (rsp_way !== WAYW'(i) || rsp_evict !== 1'b0) begin
                fails++;
                $display("FAIL iso_s3_%0d: way=%0d evict=%0b, want %0d/0", i, rsp_way, rsp_evict, i);
            end
        end
        send(FILL, 2'd1, '0);
        tests++;
        if (rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL iso_s1: way=%0d evict=%0b, want 0/0", rsp_way, rsp_evict);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_set(2'd1);
        rsp_ready = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_way !== 2'd0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: valid=%0b way=%0d ready=%0b, want 0/0/1", rsp_valid, rsp_way, req_ready);
        end
        @(posedge clk); #1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        send(FILL, 2'd1, '0);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_way !== 2'd0 || rsp_evict !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_fill: valid=%0b way=%0d evict=%0b, want 1/0/0", rsp_valid, rsp_way, rsp_evict);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = NOP;
        req_set   = '0;
        req_way   = '0;
        rsp_ready = 1'b1;
        #2;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        test_cold_fill();
        test_touch_protects();
        test_inval_reuse();
        test_backpressure();
        test_set_isolation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
